// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU op sequencer: datapath width, opcodes,
// FSM state encoding and multiply iteration count.
package alu_seq_pkg;

    localparam int WIDTH     = 8;
    localparam int MUL_ITERS = 8;
    localparam int CNT_W     = $clog2(MUL_ITERS);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_NEG = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_RESP = 2'd3
    } state_t;

endpackage

// File: rtl/alu_op_sequencer_adder8.sv
// 8-bit ripple-carry adder built from a chain of full-adder cells.
module adder8
    import alu_seq_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[WIDTH];

endmodule

// File: rtl/alu_op_sequencer.sv
// Command/response ALU sequencer: single-cycle ops plus an 8-step
// shift-and-add multiplier, all sharing one ripple adder.
module alu_op_sequencer
    import alu_seq_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_y,
    output logic       rsp_carry,
    output logic       rsp_zero,
    output logic       rsp_err,
    output logic       busy
);

    state_t state_q, state_d;

    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;        // operand A, doubles as shifting multiplicand
    logic [WIDTH-1:0] b_q, b_d;        // operand B, doubles as shifting multiplier
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             shout_q, shout_d;

    logic [WIDTH-1:0] rsp_y_q, rsp_y_d;
    logic             rsp_carry_q, rsp_carry_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_err_q, rsp_err_d;
    logic             rsp_valid_q, rsp_valid_d;

    logic [WIDTH-1:0] add_x, add_y, add_sum;
    logic             add_cin, add_cout;
    logic             accept;
    logic             last_iter;

    assign accept    = cmd_valid && cmd_ready;
    assign last_iter = (cnt_q == CNT_W'(MUL_ITERS - 1));

    adder8 u_adder (
        .a    (add_x),
        .b    (add_y),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // NOTE: async reset lives in the sensitivity list; every state flop,
    // including the datapath registers, is cleared so reset aborts cleanly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            // NOTE: sequential state always uses non-blocking assignment so all
            // flops sample pre-edge values regardless of statement order.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept) state_d = (cmd_op == OP_MUL) ? ST_MUL : ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_MUL:  if (last_iter) state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == ST_IDLE) && !reset;
        busy      = (state_q != ST_IDLE);
    end

    always_comb begin
        add_x   = '0;
        add_y   = '0;
        add_cin = 1'b0;
        if (state_q == ST_MUL) begin
            add_x = acc_q;
            add_y = a_q;
        end else if (state_q == ST_EXEC) begin
            unique case (op_q)
                OP_ADD: begin add_x = a_q;  add_y = b_q;  end
                OP_SUB: begin add_x = a_q;  add_y = ~b_q; add_cin = 1'b1; end
                OP_NEG: begin add_x = ~a_q; add_cin = 1'b1; end
                default: ;
            endcase
        end
    end

    always_comb begin
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        shout_d     = shout_q;
        rsp_y_d     = rsp_y_q;
        rsp_carry_d = rsp_carry_q;
        rsp_zero_d  = rsp_zero_q;
        rsp_err_d   = rsp_err_q;
        rsp_valid_d = rsp_valid_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d = cmd_op;
                    a_d  = cmd_a;
                    b_d  = cmd_b;
                    if (cmd_op == OP_MUL) begin
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                        shout_d = 1'b0;
                    end
                end
            end
            ST_EXEC: begin
                rsp_err_d   = 1'b0;
                rsp_carry_d = 1'b0;
                unique case (op_q)
                    OP_ADD, OP_SUB, OP_NEG: begin
                        rsp_y_d     = add_sum;
                        rsp_carry_d = add_cout;
                    end
                    OP_AND: rsp_y_d = a_q & b_q;
                    OP_OR:  rsp_y_d = a_q | b_q;
                    OP_XOR: rsp_y_d = a_q ^ b_q;
                    default: begin
                        rsp_y_d   = '0;
                        rsp_err_d = 1'b1;
                    end
                endcase
                rsp_zero_d  = (rsp_y_d == '0);
                rsp_valid_d = 1'b1;
            end
            ST_MUL: begin
                // Truncated sum is only wrong if it carried or if a bit already
                // left the top of the multiplicand is part of this addend.
                if (b_q[0]) begin
                    acc_d = add_sum;
                    ovf_d = ovf_q | add_cout | shout_q;
                end
                shout_d = shout_q | a_q[WIDTH-1];
                a_d     = a_q << 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                if (last_iter) begin
                    rsp_y_d     = acc_d;
                    rsp_carry_d = ovf_d;
                    rsp_zero_d  = (acc_d == '0);
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                end
            end
            ST_RESP: if (rsp_ready) rsp_valid_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            shout_q     <= 1'b0;
            rsp_y_q     <= '0;
            rsp_carry_q <= 1'b0;
            rsp_zero_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            shout_q     <= shout_d;
            rsp_y_q     <= rsp_y_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_zero_q  <= rsp_zero_d;
            rsp_err_q   <= rsp_err_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign rsp_y     = rsp_y_q;
    assign rsp_carry = rsp_carry_q;
    assign rsp_zero  = rsp_zero_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_valid = rsp_valid_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed corner cases, reset
// abort, backpressure, then randomized commands against an arithmetic model.
`timescale 1ns/1ps
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_y;
    logic       rsp_carry;
    logic       rsp_zero;
    logic       rsp_err;
    logic       busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_op_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_carry (rsp_carry),
        .rsp_zero  (rsp_zero),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural reference: plain integer arithmetic on the opcode table.
    function automatic void model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] y, output logic c, output logic e);
        int p;
        y = 8'h00; c = 1'b0; e = 1'b0;
        case (op)
            4'b0000: begin p = int'(a) + int'(b); y = p[7:0]; c = (p > 255); end
            4'b0001: begin y = a - b; c = (a >= b); end
            4'b0010: y = a & b;
            4'b0011: y = a | b;
            4'b0100: y = a ^ b;
            4'b1100: begin y = 8'h00 - a; c = (a == 8'h00); end
            4'b1000: begin p = int'(a) * int'(b); y = p[7:0]; c = (p > 255); end
            default: e = 1'b1;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                           input int hold, input bit poke);
        logic [7:0] ey;
        logic       ec, ee;
        int         lat, cyc;
        string      id;
        model(op, a, b, ey, ec, ee);
        lat = (op == 4'b1000) ? 8 : 1;
        id  = $sformatf("op=%h a=%h b=%h", op, a, b);
        check({id, " ready"}, 8'(cmd_ready), 8'h01);
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
        step();
        cmd_valid = 1'b0; cmd_a = $urandom; cmd_b = $urandom;
        check({id, " busy"}, 8'(busy), 8'h01);
        cyc = 0;
        while (!rsp_valid && cyc < 20) begin
            step();
            cyc++;
        end
        check({id, " latency"}, 8'(cyc), 8'(lat));
        for (int i = 0; i <= hold; i++) begin
            check({id, " y"},     rsp_y,            ey);
            check({id, " carry"}, 8'(rsp_carry),    8'(ec));
            check({id, " zero"},  8'(rsp_zero),     8'(ey == 8'h00));
            check({id, " err"},   8'(rsp_err),      8'(ee));
            check({id, " valid"}, 8'(rsp_valid),    8'h01);
            check({id, " noacc"}, 8'(cmd_ready),    8'h00);
            if (i < hold) begin
                if (poke && i == 1) begin
                    cmd_valid = 1'b1; cmd_op = 4'b0000; cmd_a = 8'h11; cmd_b = 8'h22;
                end
                step();
                cmd_valid = 1'b0;
            end
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check({id, " idle"},  8'(busy),      8'h00);
        check({id, " rvoff"}, 8'(rsp_valid), 8'h00);
    endtask

    initial begin
        logic [3:0] legal [7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b1100, 4'b1000};
        logic [3:0] rop;
        int         r;

        reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
        step();
        step();
        check("rst ready", 8'(cmd_ready), 8'h00);
        check("rst valid", 8'(rsp_valid), 8'h00);
        check("rst y",     rsp_y,         8'h00);
        check("rst flags", 8'({rsp_carry, rsp_zero, rsp_err, busy}), 8'h00);
        reset = 1'b0;
        #1;
        check("post rst ready", 8'(cmd_ready), 8'h01);

        run_cmd(4'b0000, 8'h7F, 8'h01, 0, 1'b0);
        run_cmd(4'b0001, 8'h05, 8'h07, 0, 1'b0);
        run_cmd(4'b1100, 8'h00, 8'h00, 0, 1'b0);
        run_cmd(4'b1100, 8'h01, 8'h00, 0, 1'b0);
        run_cmd(4'b1000, 8'h0D, 8'h0B, 0, 1'b0);
        run_cmd(4'b1000, 8'h10, 8'h10, 0, 1'b0);
        run_cmd(4'b1000, 8'h80, 8'h02, 0, 1'b0);
        run_cmd(4'b0111, 8'hFF, 8'h00, 0, 1'b0);
        run_cmd(4'b0010, 8'hF0, 8'h3C, 5, 1'b1);

        // Abort a multiply mid-iteration with an asynchronous reset.
        cmd_valid = 1'b1; cmd_op = 4'b1000; cmd_a = 8'hFF; cmd_b = 8'hFF;
        step();
        cmd_valid = 1'b0;
        step(); step(); step();
        #2 reset = 1'b1;
        #1;
        check("abort valid", 8'(rsp_valid), 8'h00);
        check("abort y",     rsp_y,         8'h00);
        check("abort flags", 8'({rsp_carry, rsp_zero, rsp_err, busy}), 8'h00);
        check("abort ready", 8'(cmd_ready), 8'h00);
        step();
        reset = 1'b0;
        #1;
        check("abort idle", 8'({cmd_ready, busy}), 8'h02);
        for (int i = 0; i < 10; i++) begin
            step();
            check("abort norsp", 8'(rsp_valid), 8'h00);
        end
        run_cmd(4'b0000, 8'h02, 8'h03, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            rop = (r < 7) ? legal[r] : 4'($urandom_range(0, 15));
            run_cmd(rop, 8'($urandom), 8'($urandom), $urandom_range(0, 3), n[0]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
